fact_unit: RTL

- Iterative factorial engine; the responder side of the control unit's FACT/FACT_END handshake.
- Control unit raises FACT with SEL_X or SEL_Y. fact_unit latches the selected register value, computes N! by repeated multiply, and returns a one-cycle FACT_END with RESULT.
- Sits beside the ALU. RESULT is written back to ACC by the datapath on FACT_END; OVF goes to the flag register.

---
 rtl/calc_pkg.sv | 14 +
 rtl/fact_unit_if.sv | 24 ++
 rtl/fact_mult.sv | 15 +
 rtl/fact_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator datapath blocks.
package calc_pkg;

  localparam int unsigned FACT_WIDTH = 16;
  localparam int unsigned FACT_MAX_N = 8;
  localparam logic [5:0]  OP_FACT    = 6'b011000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } fact_state_t;

endpackage

// File: rtl/fact_unit_if.sv
// FACT/FACT_END handshake between the control unit (master) and fact_unit (slave).
interface fact_unit_if #(
  parameter int unsigned Width = calc_pkg::FACT_WIDTH
);
  logic             fact;
  logic             sel_x;
  logic             sel_y;
  logic [Width-1:0] x_in;
  logic [Width-1:0] y_in;
  logic             busy;
  logic             fact_end;
  logic [Width-1:0] result;
  logic             ovf;

  modport master (
    output fact, sel_x, sel_y, x_in, y_in,
    input  busy, fact_end, result, ovf
  );

  modport slave (
    input  fact, sel_x, sel_y, x_in, y_in,
    output busy, fact_end, result, ovf
  );
endinterface

// File: rtl/fact_mult.sv
// Combinational Width x Width multiply: low word plus a flag for a nonzero upper half.
module fact_mult #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] lo,
  output logic             ovf
);
  logic [2*Width-1:0] full;

  assign full = {{Width{1'b0}}, a} * {{Width{1'b0}}, b};
  assign lo   = full[Width-1:0];
  assign ovf  = |full[2*Width-1:Width];
endmodule

// File: rtl/fact_unit.sv
// Iterative factorial engine answering the control unit's FACT request with a FACT_END pulse.
module fact_unit
  import calc_pkg::*;
#(
  parameter int unsigned Width = FACT_WIDTH,
  parameter int unsigned MaxN  = FACT_MAX_N
) (
  input  logic        clk,
  input  logic        rst_n,
  fact_unit_if.slave  bus
);
  fact_state_t      state_q, state_d;
  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] n_q, n_d;
  logic [Width-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             fact_q;
  logic             fact_end_q;
  logic [Width-1:0] n_in;
  logic [Width-1:0] prod_lo;
  logic             prod_ovf;
  logic             start;

  assign n_in  = bus.sel_x ? bus.x_in : bus.y_in;
  assign start = (state_q == IDLE) && bus.fact && !fact_q && (bus.sel_x || bus.sel_y);

  fact_mult #(.Width(Width)) u_mult (
    .a   (acc_q),
    .b   (n_q),
    .lo  (prod_lo),
    .ovf (prod_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    n_d      = n_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sticky_d = 1'b0;
          if (n_in > Width'(MaxN)) begin
            result_d = '1;
            ovf_d    = 1'b1;
            state_d  = DONE;
          end else begin
            n_d     = n_in;
            acc_d   = Width'(1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (n_q <= Width'(1)) begin
          result_d = sticky_q ? '1 : acc_q;
          ovf_d    = sticky_q;
          state_d  = DONE;
        end else if (n_q == Width'(2)) begin
          // Last multiply lands straight in the result register.
          result_d = (sticky_q || prod_ovf) ? '1 : prod_lo;
          ovf_d    = sticky_q || prod_ovf;
          state_d  = DONE;
        end else begin
          acc_d    = prod_lo;
          n_d      = n_q - Width'(1);
          sticky_d = sticky_q || prod_ovf;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      n_q        <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
      fact_q     <= 1'b0;
      fact_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
      fact_q     <= bus.fact;
      fact_end_q <= (state_d == DONE);
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.fact_end = fact_end_q;
  assign bus.result   = result_q;
  assign bus.ovf      = ovf_q;
endmodule
